// File: rtl/icache_axi_refill_pkg.sv
// Shared instruction-side cache and AXI definitions used by the line refill engine.
package icache_axi_refill_pkg;

    localparam int ICACHE_LINE_SIZE  = 32;
    localparam int ICACHE_LINE_WORDS = ICACHE_LINE_SIZE / 4;
    localparam int AXI_ID_WIDTH      = 4;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    typedef enum logic [2:0] {
        AXI_SIZE_1B = 3'd0,
        AXI_SIZE_2B = 3'd1,
        AXI_SIZE_4B = 3'd2,
        AXI_SIZE_8B = 3'd3
    } axi_size_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'd0,
        AXI_RESP_EXOKAY = 2'd1,
        AXI_RESP_SLVERR = 2'd2,
        AXI_RESP_DECERR = 2'd3
    } axi_resp_t;

    typedef enum logic [1:0] {
        REFILL_IDLE,
        REFILL_AR,
        REFILL_R,
        REFILL_DONE
    } icache_refill_state_t;

endpackage

// File: rtl/icache_axi_refill.sv
// ICACHE line refill engine: one miss -> one AXI INCR burst -> one assembled line
// returned with an error flag over a valid/ready handshake.
module icache_axi_refill
    import icache_axi_refill_pkg::*;
#(
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [LINE_WORDS*32-1:0]  resp_data,
    output logic                      resp_err,
    output logic [AXI_ID_WIDTH-1:0]   arid,
    output logic [31:0]               araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [AXI_ID_WIDTH-1:0]   rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    icache_refill_state_t state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [31:0]          addr_reg;
    logic                 req_ready_reg;
    logic                 arvalid_reg;
    logic                 rready_reg;
    logic                 resp_valid_reg;
    logic                 err_reg;
    logic                 beat_fire;
    logic                 beat_bad;
    logic                 addr_lsb_unused;

    assign addr_lsb_unused = ^req_addr[4:0];
    assign beat_fire = (state_reg == REFILL_R) && rvalid && rready_reg;
    // EXOKAY counts as success; rlast must line up exactly with the final counted beat.
    assign beat_bad  = (rresp == AXI_RESP_SLVERR) || (rresp == AXI_RESP_DECERR) ||
                       (rid != AXI_ID) || (rlast != (cnt_reg == LAST_BEAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= REFILL_IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            req_ready_reg  <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                REFILL_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        addr_reg      <= {req_addr[31:5], 5'b0};
                        cnt_reg       <= '0;
                        err_reg       <= 1'b0;
                        req_ready_reg <= 1'b0;
                        arvalid_reg   <= 1'b1;
                        state_reg     <= REFILL_AR;
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                REFILL_AR: begin
                    if (arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= REFILL_R;
                    end
                end
                REFILL_R: begin
                    if (beat_fire) begin
                        if (beat_bad) begin
                            err_reg <= 1'b1;
                        end
                        // The beat count, not rlast, closes the burst.
                        if (cnt_reg == LAST_BEAT) begin
                            rready_reg     <= 1'b0;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= REFILL_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                REFILL_DONE: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= REFILL_IDLE;
                    end
                end
                default: state_reg <= REFILL_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line
            logic [31:0] word_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (beat_fire && (cnt_reg == CNT_W'(gi))) begin
                    word_reg <= rdata;
                end
            end
            assign resp_data[gi*32 +: 32] = word_reg;
        end
    endgenerate

    assign req_ready  = req_ready_reg;
    assign arvalid    = arvalid_reg;
    assign rready     = rready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = err_reg;
    assign arid       = AXI_ID;
    assign araddr     = addr_reg;
    assign arlen      = 8'(LINE_WORDS - 1);
    assign arsize     = AXI_SIZE_4B;
    assign arburst    = AXI_BURST_INCR;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for icache_axi_refill: drives misses against a scripted AXI slave
// and checks AR payload, assembled line, error flag, latency and handshakes.
module tb_icache_axi_refill;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         resp_valid;
    logic         resp_ready;
    logic [255:0] resp_data;
    logic         resp_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int checks_cnt;
    int fail_cnt;

    icache_axi_refill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    // One complete miss. rlast_mask bit k = rlast on beat k; bad_beat gets bad_resp.
    task automatic do_miss(input string name, input logic [31:0] addr, input logic [31:0] exp_araddr,
                           input int ar_delay, input bit gap, input logic [7:0] rlast_mask,
                           input int bad_beat, input logic [1:0] bad_resp, input int resp_delay,
                           input logic [31:0] base, input logic exp_err, input int exp_lat);
        int cyc;
        int k;
        int guard;
        bit ph;
        logic [255:0] exp_line;
        exp_line = make_line(base);
        check({name, "_req_ready"}, 256'(req_ready), 256'(1));
        cyc = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk); cyc++;
        req_valid = 1'b0;
        check({name, "_arvalid"}, 256'(arvalid), 256'(1));
        check({name, "_araddr"}, 256'(araddr), 256'(exp_araddr));
        check({name, "_ar_payload"}, 256'({arid, arlen, arsize, arburst}), 256'({4'd0, 8'd7, 3'd2, 2'd1}));
        for (int i = 0; i < ar_delay; i++) begin
            arready = 1'b0;
            @(negedge clk); cyc++;
            check({name, "_arvalid_hold"}, 256'({arvalid, araddr}), 256'({1'b1, exp_araddr}));
        end
        arready = 1'b1;
        @(negedge clk); cyc++;
        arready = 1'b0;
        check({name, "_ar_done"}, 256'({arvalid, rready}), 256'({1'b0, 1'b1}));
        k = 0;
        guard = 0;
        ph = !gap;
        while (k < 8 && guard < 100) begin
            check({name, "_resp_early"}, 256'(resp_valid), 256'(0));
            if (ph) begin
                rvalid = 1'b1;
                rdata  = base + 32'(k);
                rresp  = (k == bad_beat) ? bad_resp : 2'b00;
                rlast  = rlast_mask[k];
                rid    = 4'd0;
            end else begin
                rvalid = 1'b0;
            end
            @(negedge clk); cyc++; guard++;
            if (ph) k++;
            if (gap) ph = !ph;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        check({name, "_beats"}, 256'(k), 256'(8));
        check({name, "_resp_valid"}, 256'({resp_valid, rready}), 256'({1'b1, 1'b0}));
        if (exp_lat >= 0) check({name, "_latency"}, 256'(cyc), 256'(exp_lat));
        check({name, "_resp_data"}, resp_data, exp_line);
        check({name, "_resp_err"}, 256'(resp_err), 256'(exp_err));
        for (int i = 0; i < resp_delay; i++) begin
            resp_ready = 1'b0;
            @(negedge clk);
            check({name, "_done_hold"}, 256'({resp_valid, req_ready, resp_err}), 256'({1'b1, 1'b0, exp_err}));
            check({name, "_done_data"}, resp_data, exp_line);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({name, "_back_idle"}, 256'({resp_valid, req_ready}), 256'({1'b0, 1'b1}));
        $display("txn %s addr=%h err=%0d cycles=%0d", name, addr, resp_err, cyc);
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        arready    = 1'b0;
        rid        = '0;
        rdata      = '0;
        rresp      = '0;
        rlast      = 1'b0;
        rvalid     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", 256'({req_ready, arvalid, rready, resp_valid, resp_err}), 256'(0));
        check("reset_data", resp_data, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 256'(req_ready), 256'(1));

        do_miss("basic",  32'h0000_1234, 32'h0000_1220, 0, 1'b0, 8'h80, -1, 2'b00, 0, 32'hA0, 1'b0, 10);
        do_miss("stall",  32'h8000_00FF, 32'h8000_00E0, 3, 1'b1, 8'h80, -1, 2'b00, 0, 32'hB000_0010, 1'b0, -1);
        do_miss("slverr", 32'h0000_2040, 32'h0000_2040, 0, 1'b0, 8'h80, 4, 2'b10, 0, 32'hC0, 1'b1, 10);
        do_miss("clean",  32'h0000_205C, 32'h0000_2040, 0, 1'b0, 8'h80, -1, 2'b00, 0, 32'hD0, 1'b0, 10);
        do_miss("exokay", 32'h0000_3000, 32'h0000_3000, 0, 1'b0, 8'h80, 2, 2'b01, 0, 32'h11, 1'b0, 10);
        do_miss("decerr", 32'h0000_3001, 32'h0000_3000, 1, 1'b0, 8'h80, 7, 2'b11, 0, 32'h21, 1'b1, 11);
        do_miss("early",  32'h0000_4010, 32'h0000_4000, 0, 1'b0, 8'hA0, -1, 2'b00, 0, 32'hE0, 1'b1, 10);
        do_miss("nolast", 32'h0000_5000, 32'h0000_5000, 0, 1'b0, 8'h00, -1, 2'b00, 0, 32'hF0, 1'b1, 10);
        do_miss("hold",   32'hFFFF_FFFF, 32'hFFFF_FFE0, 0, 1'b0, 8'h80, -1, 2'b00, 5, 32'h1234_5670, 1'b0, 10);

        // Reset in the middle of a burst.
        req_valid = 1'b1;
        req_addr  = 32'h0000_6000;
        @(negedge clk);
        req_valid = 1'b0;
        arready   = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1;
            rdata  = 32'h55 + 32'(k);
            rlast  = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_outs", 256'({arvalid, rready, resp_valid, req_ready}), 256'(0));
        check("midrst_data", resp_data, 256'(0));
        rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", 256'(req_ready), 256'(1));
        $display("txn midreset");
        do_miss("after_rst", 32'h0000_7008, 32'h0000_7000, 0, 1'b0, 8'h80, -1, 2'b00, 0, 32'h77, 1'b0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
